uart_resp_tx: RTL
=================

UART_RESP_TX -- requirements
Module: uart_resp_tx

Interface
REQ-001 clk  input  1  system clock; all logic on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 resp_ok  input  1  one-cycle pulse: write acknowledged.
REQ-004 resp_data  input  1  one-cycle pulse: read data available.
REQ-005 resp_err  input  1  one-cycle pulse: command rejected.
REQ-006 resp_addr  input  8  register address, valid with resp_ok/resp_data.
REQ-007 resp_data_byte  input  8  read data, valid with resp_data.
REQ-008 resp_err_code  input  8  error code, valid with resp_err.
REQ-009 tx_byte  output  8  byte offered to UART transmitter.
REQ-010 tx_valid  output  1  tx_byte valid; held until accepted.
REQ-011 tx_ready  input  1  transmitter accepts tx_byte this cycle.
REQ-012 busy  output  1  high while a frame is active or pending.
REQ-013 overflow  output  1  sticky; a response was dropped.

Function
REQ-014 Frame formats (ASCII): OK -> 'K'(0x4B), addr, 0x0A; DATA -> 'D'(0x44), addr, data, 0x0A; ERR -> 'E'(0x45), err_code, 0x0A.
REQ-015 Simultaneous response pulses shall resolve by priority err > data > ok; only one frame is generated.
REQ-016 All response fields shall be captured on the pulse edge; later input changes do not affect the frame.
REQ-017 FSM states IDLE, HDR, ARG1, ARG2, TERM; ARG2 used only for DATA frames; OK/ERR go ARG1 -> TERM.
REQ-018 Byte transfer occurs on a rising edge with tx_valid && tx_ready; the state advances only on transfer.
REQ-019 tx_byte shall remain stable while tx_valid is high and tx_ready is low.
REQ-020 Latency: pulse sampled in IDLE at edge N -> tx_valid=1 with header byte during cycle N+1.
REQ-021 One pending slot: a pulse arriving while a frame is active shall be stored if the slot is empty.
REQ-022 On TERM transfer with the pending slot full, the pending frame shall load and its header appear next cycle, with tx_valid staying high (no bubble).
REQ-023 On TERM transfer with the slot empty and a simultaneous new pulse, the new frame shall load directly as the active frame (no bubble).
REQ-024 On TERM transfer with the slot full and a simultaneous new pulse, pending moves to active and the new pulse fills the slot.
REQ-025 A pulse arriving while active and the slot is full (no TERM transfer that edge) shall be dropped and overflow set to 1.
REQ-026 overflow shall clear only on reset.
REQ-027 busy = (state != IDLE) || pending slot full; in IDLE tx_valid shall be 0.

Reset
REQ-028 On rst: state IDLE, pending slot empty, tx_valid=0, tx_byte=0x00, busy=0, overflow=0.
REQ-029 rst mid-frame shall abort the frame; no further bytes of it are emitted; pulses coinciding with rst are ignored.

Structure
REQ-030 Shared package uart_regfile_pkg shall hold the char constants 'K','D','E',0x0A, the error codes (UNKNOWN_CMD=0x01, BAD_ADDR=0x02) and the FSM state encoding.
REQ-031 No sub-module; active and pending frames use one frame-record type from the package.

Verification
REQ-032 resp_ok addr=0x03, tx_ready=1 -> bytes 4B 03 0A on consecutive cycles, tx_valid from cycle N+1.
REQ-033 resp_data addr=0x03 data=0xB3, tx_ready toggling 1/0 -> bytes 44 03 B3 0A, tx_byte stable during stalls.
REQ-034 resp_err code=0x02 and resp_ok in the same cycle -> only 45 02 0A.
REQ-035 tx_ready=0; pulses ok(0x01), err(0x01), data(0x05,0x77) -> first two frames emitted in order once tx_ready=1, third dropped, overflow=1.
REQ-036 resp_ok while last byte 0x0A is accepted -> next 4B header follows with no idle cycle.
REQ-037 rst asserted after the 'D' header is sent -> tx_valid=0 next cycle, busy=0, no remaining bytes.

Source files
------------

// File: rtl/uart_regfile_pkg.sv
// Shared definitions for the register-file response path: the ASCII frame
// characters, the error codes, the transmit FSM state encoding and the
// frame record used for both the active and the pending response.
package uart_regfile_pkg;

  // Frame characters
  localparam logic [7:0] CH_K  = 8'h4B;  // 'K' write acknowledged
  localparam logic [7:0] CH_D  = 8'h44;  // 'D' read data
  localparam logic [7:0] CH_E  = 8'h45;  // 'E' command rejected
  localparam logic [7:0] CH_LF = 8'h0A;  // frame terminator

  // Error codes carried in ERR frames
  localparam logic [7:0] ERR_UNKNOWN_CMD = 8'h01;
  localparam logic [7:0] ERR_BAD_ADDR    = 8'h02;

  // Transmit FSM: ARG2 is only visited by DATA frames
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_ARG1 = 3'd2,
    ST_ARG2 = 3'd3,
    ST_TERM = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    FR_OK   = 2'd0,
    FR_DATA = 2'd1,
    FR_ERR  = 2'd2
  } frame_kind_t;

  // One captured response. arg1 is the address (OK/DATA) or the error
  // code (ERR); arg2 is the read data byte and only meaningful for DATA.
  typedef struct packed {
    frame_kind_t kind;
    logic [7:0]  arg1;
    logic [7:0]  arg2;
  } frame_t;

  // Header character that opens a frame of the given kind
  function automatic logic [7:0] header_char(input frame_kind_t kind);
    logic [7:0] ch;
    case (kind)
      FR_DATA: ch = CH_D;
      FR_ERR:  ch = CH_E;
      default: ch = CH_K;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/uart_resp_tx.sv
// Serialises register-file responses (OK / DATA / ERR) into short ASCII
// frames offered byte-by-byte to a UART transmitter over a valid/ready
// handshake. One response can be queued behind the frame in flight;
// anything beyond that is dropped and flagged on the sticky overflow.
module uart_resp_tx
  import uart_regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       resp_ok,
  input  logic       resp_data,
  input  logic       resp_err,
  input  logic [7:0] resp_addr,
  input  logic [7:0] resp_data_byte,
  input  logic [7:0] resp_err_code,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       overflow
);

  state_t     state_reg;
  frame_t     active_reg;
  frame_t     pending_reg;
  logic       pending_valid_reg;
  logic [7:0] tx_byte_reg;
  logic       tx_valid_reg;
  logic       overflow_reg;

  logic       new_pulse;
  frame_t     new_frame;
  logic       xfer;

  assign new_pulse = resp_ok | resp_data | resp_err;
  assign xfer      = tx_valid_reg & tx_ready;

  // Capture the incoming response, resolving simultaneous pulses err > data > ok
  always_comb begin
    new_frame.kind = FR_OK;
    new_frame.arg1 = resp_addr;
    new_frame.arg2 = 8'h00;
    if (resp_err) begin
      new_frame.kind = FR_ERR;
      new_frame.arg1 = resp_err_code;
    end else if (resp_data) begin
      new_frame.kind = FR_DATA;
      new_frame.arg2 = resp_data_byte;
    end
  end

  // Frame sequencer: advances one byte per accepted transfer, chains the
  // pending or a coincident new frame straight after the terminator, and
  // queues/drops responses that arrive while a frame is in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= ST_IDLE;
      active_reg        <= '0;
      pending_reg       <= '0;
      pending_valid_reg <= 1'b0;
      tx_byte_reg       <= 8'h00;
      tx_valid_reg      <= 1'b0;
      overflow_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // The pending slot is always empty here, so a pulse starts a frame
          if (new_pulse) begin
            active_reg   <= new_frame;
            state_reg    <= ST_HDR;
            tx_byte_reg  <= header_char(new_frame.kind);
            tx_valid_reg <= 1'b1;
          end
        end

        default: begin
          if (xfer) begin
            case (state_reg)
              ST_HDR: begin
                state_reg   <= ST_ARG1;
                tx_byte_reg <= active_reg.arg1;
              end
              ST_ARG1: begin
                if (active_reg.kind == FR_DATA) begin
                  state_reg   <= ST_ARG2;
                  tx_byte_reg <= active_reg.arg2;
                end else begin
                  state_reg   <= ST_TERM;
                  tx_byte_reg <= CH_LF;
                end
              end
              ST_ARG2: begin
                state_reg   <= ST_TERM;
                tx_byte_reg <= CH_LF;
              end
              ST_TERM: begin
                if (pending_valid_reg) begin
                  // Queued frame goes next; a coincident pulse refills the slot
                  active_reg        <= pending_reg;
                  state_reg         <= ST_HDR;
                  tx_byte_reg       <= header_char(pending_reg.kind);
                  pending_valid_reg <= new_pulse;
                  if (new_pulse) begin
                    pending_reg <= new_frame;
                  end
                end else if (new_pulse) begin
                  // Coincident pulse becomes the active frame without a bubble
                  active_reg  <= new_frame;
                  state_reg   <= ST_HDR;
                  tx_byte_reg <= header_char(new_frame.kind);
                end else begin
                  state_reg    <= ST_IDLE;
                  tx_byte_reg  <= 8'h00;
                  tx_valid_reg <= 1'b0;
                end
              end
              default: begin
                state_reg    <= ST_IDLE;
                tx_byte_reg  <= 8'h00;
                tx_valid_reg <= 1'b0;
              end
            endcase
          end

          // Pulses not consumed by a terminator hand-off go to the slot or are lost
          if (new_pulse && !(xfer && (state_reg == ST_TERM))) begin
            if (!pending_valid_reg) begin
              pending_reg       <= new_frame;
              pending_valid_reg <= 1'b1;
            end else begin
              overflow_reg <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign tx_byte  = tx_byte_reg;
  assign tx_valid = tx_valid_reg;
  assign busy     = (state_reg != ST_IDLE) || pending_valid_reg;
  assign overflow = overflow_reg;

endmodule
